// File: rtl/actel_s2_exerciser_if.sv
// Signal bundle between the S2 cell exerciser and its surroundings: run control,
// result reporting, and the stimulus/response wires of the cell under test.
interface actel_s2_exerciser_if;
  logic       start;
  logic       dut_out;
  logic       d00, d01, d10, d11;
  logic       a1, b1, a0, b0;
  logic       dut_clr;
  logic       busy;
  logic       done;
  logic       pass;
  logic [8:0] err_cnt;
  logic [7:0] first_err_vec;
  logic       first_err_valid;
  logic       clr_fail;

  modport master (
    input  start, dut_out,
    output d00, d01, d10, d11, a1, b1, a0, b0, dut_clr,
    output busy, done, pass, err_cnt, first_err_vec, first_err_valid, clr_fail
  );

  modport slave (
    output start, dut_out,
    input  d00, d01, d10, d11, a1, b1, a0, b0, dut_clr,
    input  busy, done, pass, err_cnt, first_err_vec, first_err_valid, clr_fail
  );
endinterface

// File: rtl/actel_s2_exerciser.sv
// Exhaustive exerciser for an Actel S2 registered mux cell: sweeps all 256 input vectors
// and counts output mismatches. Define ACTEL_EXER_CLR_TEST_EN to add the cell-clear check.
module actel_s2_exerciser (
  input  logic                 clk,
  input  logic                 clr,
  actel_s2_exerciser_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    FLUSH,
`ifdef ACTEL_EXER_CLR_TEST_EN
    CLRCHK,
`endif
    DONE
  } state_t;

  localparam logic [8:0] ERR_MAX = 9'd257;

  // Vector layout {d00,d01,d10,d11,a1,b1,a0,b0}; select = {a1|b1, a0&b0}
  function automatic logic expected_bit(input logic [7:0] v);
    logic [1:0] sel;
    sel = {v[3] | v[2], v[1] & v[0]};
    case (sel)
      2'b00:   return v[7];
      2'b01:   return v[6];
      2'b10:   return v[5];
      default: return v[4];
    endcase
  endfunction

  state_t     state_q, state_d;
  logic       phase_q, phase_d;
  logic [7:0] vec_q, vec_d;
  logic       vec_valid_q, vec_valid_d;
  logic [7:0] cmp_vec_q, cmp_vec_d;
  logic       cmp_valid_q, cmp_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [8:0] err_cnt_q, err_cnt_d;
  logic [7:0] fev_q, fev_d;
  logic       fev_valid_q, fev_valid_d;
  logic       mismatch;
  logic       err_inc;
`ifdef ACTEL_EXER_CLR_TEST_EN
  logic       dut_clr_q, dut_clr_d;
  logic       clr_fail_q, clr_fail_d;
  logic       clr_bad;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      vec_q       <= 8'h00;
      vec_valid_q <= 1'b0;
      cmp_vec_q   <= 8'h00;
      cmp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= 9'd0;
      fev_q       <= 8'h00;
      fev_valid_q <= 1'b0;
`ifdef ACTEL_EXER_CLR_TEST_EN
      dut_clr_q   <= 1'b0;
      clr_fail_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      vec_q       <= vec_d;
      vec_valid_q <= vec_valid_d;
      cmp_vec_q   <= cmp_vec_d;
      cmp_valid_q <= cmp_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      fev_q       <= fev_d;
      fev_valid_q <= fev_valid_d;
`ifdef ACTEL_EXER_CLR_TEST_EN
      dut_clr_q   <= dut_clr_d;
      clr_fail_q  <= clr_fail_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    vec_d       = 8'h00;
    vec_valid_d = 1'b0;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    fev_d       = fev_q;
    fev_valid_d = fev_valid_q;
    // The vector on the pins now is captured by the cell next edge and judged the edge after
    cmp_vec_d   = vec_q;
    cmp_valid_d = vec_valid_q;
    mismatch    = cmp_valid_q && (bus.dut_out != expected_bit(cmp_vec_q));
`ifdef ACTEL_EXER_CLR_TEST_EN
    dut_clr_d   = 1'b0;
    clr_fail_d  = clr_fail_q;
    clr_bad     = (state_q == CLRCHK) && phase_q && bus.dut_out;
    err_inc     = mismatch | clr_bad;
    if (clr_bad) clr_fail_d = 1'b1;
`else
    err_inc     = mismatch;
`endif

    if (err_inc && (err_cnt_q != ERR_MAX)) err_cnt_d = err_cnt_q + 9'd1;
    if (mismatch && !fev_valid_q) begin
      fev_d       = cmp_vec_q;
      fev_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = RUN;
          vec_valid_d = 1'b1;
          pass_d      = 1'b0;
          err_cnt_d   = 9'd0;
          fev_d       = 8'h00;
          fev_valid_d = 1'b0;
`ifdef ACTEL_EXER_CLR_TEST_EN
          clr_fail_d  = 1'b0;
`endif
        end
      end
      RUN: begin
        if (vec_q == 8'hFF) begin
          state_d = FLUSH;
          phase_d = 1'b0;
        end else begin
          vec_d       = vec_q + 8'd1;
          vec_valid_d = 1'b1;
        end
      end
      FLUSH: begin
        phase_d = ~phase_q;
        if (phase_q) begin
`ifdef ACTEL_EXER_CLR_TEST_EN
          state_d   = CLRCHK;
          vec_d     = 8'hFF;
          dut_clr_d = 1'b1;
`else
          state_d   = DONE;
`endif
        end
      end
`ifdef ACTEL_EXER_CLR_TEST_EN
      CLRCHK: begin
        phase_d = ~phase_q;
        if (phase_q) state_d = DONE;
        else         vec_d   = 8'hFF;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    if (state_d == DONE) pass_d = (err_cnt_d == 9'd0);
  end

  assign {bus.d00, bus.d01, bus.d10, bus.d11, bus.a1, bus.b1, bus.a0, bus.b0} = vec_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_cnt         = err_cnt_q;
  assign bus.first_err_vec   = fev_q;
  assign bus.first_err_valid = fev_valid_q;
`ifdef ACTEL_EXER_CLR_TEST_EN
  assign bus.dut_clr         = dut_clr_q;
  assign bus.clr_fail        = clr_fail_q;
`else
  assign bus.dut_clr         = 1'b0;
  assign bus.clr_fail        = 1'b0;
`endif

endmodule

// File: tb/tb_actel_s2_exerciser.sv
// Bench for actel_s2_exerciser: behavioural S2 cell with selectable faults, run results
// checked against a queue of expected outcomes. Honours ACTEL_EXER_CLR_TEST_EN.
module tb_actel_s2_exerciser;

`ifdef ACTEL_EXER_CLR_TEST_EN
  localparam int DONE_CYC = 261;
  localparam bit MACRO_ON = 1'b1;
`else
  localparam int DONE_CYC = 259;
  localparam bit MACRO_ON = 1'b0;
`endif
  localparam int TIMEOUT = 700;

  typedef struct packed {
    logic [9:0] cyc;
    logic       pass;
    logic [8:0] err;
    logic [7:0] fev;
    logic       fval;
    logic       cfail;
  } res_t;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  actel_s2_exerciser_if bus ();
  actel_s2_exerciser dut (.clk(clk), .clr(clr), .bus(bus));

  // 0 ideal, 1 d10 stuck 0, 2 output stuck 1, 3 ignores dut_clr
  int   fault;
  logic cell_q;
  logic [7:0] stim;
  assign stim = {bus.d00, bus.d01, bus.d10, bus.d11, bus.a1, bus.b1, bus.a0, bus.b0};

  function automatic logic cell_next(input logic [7:0] v, input int f);
    logic [1:0] sel;
    logic [3:0] d;
    sel = {v[3] | v[2], v[1] & v[0]};
    d   = {v[4], v[5], v[6], v[7]};
    if (f == 1 && sel == 2'b10) return 1'b0;
    return d[sel];
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr)                          cell_q <= 1'b0;
    else if (bus.dut_clr && fault != 3) cell_q <= 1'b0;
    else                              cell_q <= cell_next(stim, fault);
  end
  assign bus.dut_out = (fault == 2) ? 1'b1 : cell_q;

  int   checks;
  int   errors;
  res_t exp_q[$];

  function automatic res_t sample(input int cyc);
    res_t r;
    r.cyc   = (bus.done === 1'b1) ? 10'(cyc) : 10'd0;
    r.pass  = bus.pass;
    r.err   = bus.err_cnt;
    r.fev   = bus.first_err_vec;
    r.fval  = bus.first_err_valid;
    r.cfail = bus.clr_fail;
    return r;
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("cyc=%0d pass=%0d err=%0d fev=%02h fv=%0d cf=%0d",
                     r.cyc, r.pass, r.err, r.fev, r.fval, r.cfail);
  endfunction

  function automatic res_t mk(input int e, input logic [7:0] v, input bit fv, input bit cf);
    res_t r;
    r.cyc = 10'(DONE_CYC); r.pass = (e == 0); r.err = 9'(e);
    r.fev = v; r.fval = fv; r.cfail = cf;
    return r;
  endfunction

  task automatic start_and_wait(output res_t act);
    int cyc;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < TIMEOUT) begin
      @(posedge clk); #1;
      cyc++;
    end
    act = sample(cyc);
  endtask

  task automatic test_reset;
    logic [33:0] outs;
    clr = 1'b1;
    bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    outs = {bus.busy, bus.done, bus.pass, bus.err_cnt, bus.first_err_vec,
            bus.first_err_valid, bus.clr_fail, bus.dut_clr, stim};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs act=%h exp=0", outs);
    end
    clr = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_run busy act=%b exp=0", bus.busy);
    end
    $display("reset: outputs=%h", outs);
  endtask

  task automatic test_ideal;
    res_t act, exp;
    int   cyc;
    logic [7:0] ev;
    fault = 0;
    exp_q.push_back(mk(0, 8'h00, 1'b0, 1'b0));
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < TIMEOUT) begin
      if (cyc <= 258) begin
        ev = (cyc <= 256) ? 8'(cyc - 1) : 8'h00;
        checks++;
        if (stim !== ev || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL sweep_vec cyc=%0d act=%02h busy=%b exp=%02h busy=1", cyc, stim, bus.busy, ev);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    act = sample(cyc);
    exp = exp_q.pop_front();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL ideal_run act %s exp %s", fmt(act), fmt(exp));
    end
    checks++;
    if (stim !== 8'h00 || bus.dut_clr !== 1'b0) begin
      errors++;
      $display("FAIL done_stim act=%02h clr=%b exp=00 clr=0", stim, bus.dut_clr);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.pass !== 1'b1) begin
      errors++;
      $display("FAIL after_done act done=%b busy=%b pass=%b exp done=0 busy=0 pass=1",
               bus.done, bus.busy, bus.pass);
    end
    $display("run fault=0 %s", fmt(act));
  endtask

  task automatic test_faults;
    res_t act, exp;
    for (int f = 1; f <= 3; f++) begin
      fault = f;
      case (f)
        1:       exp_q.push_back(mk(72, 8'h24, 1'b1, 1'b0));
        2:       exp_q.push_back(mk(MACRO_ON ? 129 : 128, 8'h00, 1'b1, MACRO_ON));
        default: exp_q.push_back(mk(MACRO_ON ? 1 : 0, 8'h00, 1'b0, MACRO_ON));
      endcase
      start_and_wait(act);
      exp = exp_q.pop_front();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL fault%0d_run act %s exp %s", f, fmt(act), fmt(exp));
      end
      $display("run fault=%0d %s", f, fmt(act));
      @(posedge clk); #1;
    end
    fault = 0;
  endtask

  task automatic test_clr_midrun;
    res_t act, exp;
    int   cyc, dones, busy_seen;
    logic [33:0] outs;
    fault = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (cyc = 1; cyc < 100; cyc++) begin
      @(posedge clk); #1;
    end
    #2 clr = 1'b1;
    #1;
    outs = {bus.busy, bus.done, bus.pass, bus.err_cnt, bus.first_err_vec,
            bus.first_err_valid, bus.clr_fail, bus.dut_clr, stim};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL clr_midrun_outputs act=%h exp=0", outs);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    dones = 0;
    busy_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
      if (bus.busy !== 1'b0) busy_seen++;
    end
    checks++;
    if (dones != 0 || busy_seen != 0) begin
      errors++;
      $display("FAIL clr_no_resume act dones=%0d busy_cycles=%0d exp 0 0", dones, busy_seen);
    end
    exp_q.push_back(mk(0, 8'h00, 1'b0, 1'b0));
    start_and_wait(act);
    exp = exp_q.pop_front();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL clr_rerun act %s exp %s", fmt(act), fmt(exp));
    end
    $display("run after clr %s", fmt(act));
    @(posedge clk); #1;
  endtask

  task automatic test_restart_ignored;
    res_t act, exp;
    int   cyc, dones;
    act = '0;
    fault = 0;
    exp_q.push_back(mk(0, 8'h00, 1'b0, 1'b0));
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0;
    for (cyc = 1; cyc < DONE_CYC + 40; cyc++) begin
      if (cyc == 50) bus.start = 1'b1;
      if (cyc == 51) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        dones++;
        if (dones == 1) act = sample(cyc);
      end
      @(posedge clk); #1;
    end
    exp = exp_q.pop_front();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL restart_ignored act %s exp %s", fmt(act), fmt(exp));
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL restart_done_count act=%0d exp=1", dones);
    end
    $display("run restart-ignored %s dones=%0d", fmt(act), dones);
  endtask

  task automatic test_back_to_back;
    res_t act1, act2, exp;
    int   cyc, dones;
    act1 = '0;
    act2 = '0;
    fault = 0;
    exp_q.push_back(mk(0, 8'h00, 1'b0, 1'b0));
    exp_q.push_back(mk(0, 8'h00, 1'b0, 1'b0));
    bus.start = 1'b1;
    @(posedge clk); #1;
    dones = 0;
    for (cyc = 1; cyc < 2 * DONE_CYC + 30; cyc++) begin
      if (cyc == DONE_CYC + 2) bus.start = 1'b0;
      if (cyc == DONE_CYC + 1) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle_gap busy act=%b exp=0", bus.busy);
        end
      end
      if (bus.done === 1'b1) begin
        dones++;
        if (dones == 1) act1 = sample(cyc);
        if (dones == 2) act2 = sample(cyc - (DONE_CYC + 1));
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (act1 !== exp) begin
      errors++;
      $display("FAIL b2b_first act %s exp %s", fmt(act1), fmt(exp));
    end
    exp = exp_q.pop_front();
    checks++;
    if (act2 !== exp) begin
      errors++;
      $display("FAIL b2b_second act %s exp %s", fmt(act2), fmt(exp));
    end
    checks++;
    if (dones != 2) begin
      errors++;
      $display("FAIL b2b_done_count act=%0d exp=2", dones);
    end
    $display("run back-to-back first %s second %s", fmt(act1), fmt(act2));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    fault     = 0;
    bus.start = 1'b0;
    clr       = 1'b1;
    test_reset();
    test_ideal();
    test_faults();
    test_clr_midrun();
    test_restart_ignored();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain act=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/actel_s2_exerciser.md
ACTEL_S2_EXERCISER -- requirements
Module: actel_s2_exerciser

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising-edge; clr  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have: start  in  1  run request, sampled in IDLE only.
REQ-003 SHALL have: dut_out  in  1  registered output of the S2 cell under test.
REQ-004 SHALL have: d00, d01, d10, d11, a1, b1, a0, b0  out  1 each  stimulus to the cell, all registered.
REQ-005 SHALL have: dut_clr  out  1  registered clear to the cell.
REQ-006 SHALL have: busy  out  1; done  out  1  one-cycle pulse; pass  out  1.
REQ-007 SHALL have: err_cnt  out  9  mismatch count; first_err_vec  out  8; first_err_valid  out  1; clr_fail  out  1.

Function
REQ-008 SHALL map vector vec[7:0] = {d00,d01,d10,d11,a1,b1,a0,b0}, d00 = bit 7.
REQ-009 SHALL compute expected = d[sel], sel = {a1|b1, a0&b0}; 00->d00, 01->d01, 10->d10, 11->d11.
REQ-010 SHALL use FSM states IDLE, RUN, FLUSH, CLRCHK (macro only), DONE.
REQ-011 IDLE: start=1 at an edge -> RUN; clears err_cnt, first_err_*, clr_fail, pass; busy=1 from that edge.
REQ-012 RUN: drives vec 0..255 ascending, one per cycle, 256 cycles; then FLUSH.
REQ-013 Compare pipeline: vector driven after edge k is captured by the cell at edge k+1; dut_out compared to its expected value at edge k+2.
REQ-014 FLUSH: 2 cycles, stimulus held at 0x00, compares the last two vectors; then CLRCHK if macro defined, else DONE.
REQ-015 Each mismatch increments err_cnt (max 257, no wrap); first mismatch latches its vec into first_err_vec and sets first_err_valid.
REQ-016 DONE: one cycle, done=1, busy=0 on exit, -> IDLE.
REQ-017 pass = (err_cnt == 0) registered on DONE entry, held until next start.
REQ-018 Stimulus outputs and dut_clr SHALL be 0 in IDLE and DONE.
REQ-019 start while busy SHALL be ignored; start held high in DONE's following IDLE cycle starts a new run.
REQ-020 Macro off: done pulses exactly 259 cycles after the edge that samples start.

Reset
REQ-021 clr=1 SHALL immediately force IDLE and all outputs to 0, including mid-run; a run SHALL NOT resume on release.
REQ-022 Stale pipeline compares SHALL be discarded after clr.

Configuration
REQ-023 Macro ACTEL_EXER_CLR_TEST_EN SHALL enable CLRCHK.
REQ-024 Defined: CLRCHK cycle 1 drives vec 0xFF (expected 1) with dut_clr=1; cycle 2 drives 0xFF, dut_clr=0, and dut_out sampled at its start edge must be 0, else clr_fail=1 and err_cnt+1; done at 261 cycles.
REQ-025 Undefined: no CLRCHK state; dut_clr and clr_fail tied 0.

Verification
REQ-026 Ideal S2 model, macro off: start -> done at cycle 259, pass=1, err_cnt=0, first_err_valid=0.
REQ-027 Model with d10 stuck 0: err_cnt=72, first_err_vec=0x24, pass=0.
REQ-028 Model with output stuck 1: err_cnt=128, first_err_vec=0x00.
REQ-029 clr pulsed at RUN cycle 100: all outputs 0 immediately; no done; next start yields full clean run.
REQ-030 start re-pulsed at cycle 50 of RUN: ignored, done still at cycle 259, single done pulse.
REQ-031 Macro on, model ignoring clear: done at cycle 261, clr_fail=1, err_cnt=1, pass=0; compliant model: pass=1.
